region_flag_ctrl: RTL and testbench

REGION_FLAG_CTRL -- requirements
Module: region_flag_ctrl

---
 rtl/region_flag_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_region_flag_ctrl.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/region_flag_ctrl.sv
// region_flag_ctrl: splits each line of active video into four equal-width
// vertical regions (red, green, blue, yellow). It counts glove-coloured pixels
// per region over a frame. At each frame_end it picks the winning region.
// A small FSM debounces the winner: a region must win CONFIRM_FRAMES frames in
// a row before it is asserted. An asserted region persists for HOLD_FRAMES
// frames without a win.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst_n        synchronous active-low reset
//   enable       high = running, low = forced idle (state and counters cleared)
//   pix_valid    current pixel lies in active video
//   x_pos        horizontal coordinate of the current pixel
//   hit          current pixel classified as glove colour
//   frame_end    single-cycle pulse after the last active pixel of a frame
//   red_flag .. yellow_flag  registered one-hot (or all-zero) active region
//   en_regions   registered, high exactly when one region flag is high
module region_flag_ctrl #(
  parameter int unsigned H_ACTIVE       = 640,
  parameter int unsigned THRESH         = 2000,
  parameter int unsigned CONFIRM_FRAMES = 3,   // 1..15
  parameter int unsigned HOLD_FRAMES    = 15   // 1..255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       pix_valid,
  input  logic [9:0] x_pos,
  input  logic       hit,
  input  logic       frame_end,
  output logic       red_flag,
  output logic       green_flag,
  output logic       blue_flag,
  output logic       yellow_flag,
  output logic       en_regions
);

  localparam int unsigned RegionW = H_ACTIVE / 4;

  localparam logic [10:0] Bound1   = 11'(RegionW);
  localparam logic [10:0] Bound2   = 11'(2 * RegionW);
  localparam logic [10:0] Bound3   = 11'(3 * RegionW);
  localparam logic [10:0] BoundEnd = 11'(H_ACTIVE);
  localparam logic [18:0] CntMax   = '1;
  localparam logic [18:0] Thresh   = 19'(THRESH);
  localparam logic [3:0]  ConfN    = 4'(CONFIRM_FRAMES);
  localparam logic [7:0]  HoldN    = 8'(HOLD_FRAMES);

  typedef enum logic [1:0] {StIdle, StCand, StActive} state_e;

  // Pixel-to-region decode
  logic [10:0] x_ext;
  logic [1:0]  pix_region;
  logic        pix_in_range;

  always_comb begin
    x_ext        = {1'b0, x_pos};
    pix_in_range = (x_ext < BoundEnd);
    if (x_ext < Bound1) begin
      pix_region = 2'd0;
    end else if (x_ext < Bound2) begin
      pix_region = 2'd1;
    end else if (x_ext < Bound3) begin
      pix_region = 2'd2;
    end else begin
      pix_region = 2'd3;
    end
  end

  // Per-region hit counters. A pixel arriving with frame_end is dropped and
  // the counters restart from zero for the next frame.
  logic [18:0] cnt_q [4];

  always_ff @(posedge clk) begin
    if (!rst_n || !enable || frame_end) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (pix_valid && hit && pix_in_range && (cnt_q[pix_region] != CntMax)) begin
      cnt_q[pix_region] <= cnt_q[pix_region] + 19'd1;
    end
  end

  // Winner: largest qualifying count, strict '>' keeps ties on the lowest index
  logic        win_valid;
  logic [1:0]  win_idx;
  logic [18:0] win_cnt;

  always_comb begin
    win_valid = 1'b0;
    win_idx   = 2'd0;
    win_cnt   = '0;
    for (int i = 0; i < 4; i++) begin
      if ((cnt_q[i] >= Thresh) && (!win_valid || (cnt_q[i] > win_cnt))) begin
        win_valid = 1'b1;
        win_idx   = 2'(i);
        win_cnt   = cnt_q[i];
      end
    end
  end

  // Debounce FSM
  state_e     state_q, state_d;
  logic [1:0] cand_q, cand_d;
  logic [3:0] conf_q, conf_d;
  logic [1:0] act_q, act_d;
  logic [7:0] hold_q, hold_d;
  logic [1:0] pend_q, pend_d;
  logic [3:0] pend_cnt_q, pend_cnt_d;
  logic [3:0] conf_inc;
  logic [3:0] pend_nxt;

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    conf_d     = conf_q;
    act_d      = act_q;
    hold_d     = hold_q;
    pend_d     = pend_q;
    pend_cnt_d = pend_cnt_q;
    conf_inc   = conf_q + 4'd1;
    // A change of pending region restarts its streak at 1
    pend_nxt   = ((win_idx == pend_q) && (pend_cnt_q != 4'd0)) ? pend_cnt_q + 4'd1 : 4'd1;

    if (frame_end) begin
      unique case (state_q)
        StIdle: begin
          if (win_valid) begin
            if (ConfN == 4'd1) begin
              state_d = StActive;
              act_d   = win_idx;
              hold_d  = HoldN;
            end else begin
              state_d = StCand;
              cand_d  = win_idx;
              conf_d  = 4'd1;
            end
          end
        end

        StCand: begin
          if (!win_valid) begin
            state_d = StIdle;
            conf_d  = 4'd0;
          end else if (win_idx == cand_q) begin
            if (conf_inc == ConfN) begin
              state_d = StActive;
              act_d   = cand_q;
              hold_d  = HoldN;
              conf_d  = 4'd0;
            end else begin
              conf_d = conf_inc;
            end
          end else begin
            cand_d = win_idx;
            conf_d = 4'd1;
          end
        end

        StActive: begin
          if (win_valid && (win_idx == act_q)) begin
            hold_d     = HoldN;
            pend_cnt_d = 4'd0;
          end else if (win_valid && (pend_nxt == ConfN)) begin
            // A completed switch wins over hold expiry in the same frame
            act_d      = win_idx;
            hold_d     = HoldN;
            pend_cnt_d = 4'd0;
          end else begin
            if (win_valid) begin
              pend_d     = win_idx;
              pend_cnt_d = pend_nxt;
            end else begin
              pend_cnt_d = 4'd0;
            end
            if (hold_q <= 8'd1) begin
              state_d    = StIdle;
              hold_d     = 8'd0;
              pend_cnt_d = 4'd0;
              conf_d     = 4'd0;
            end else begin
              hold_d = hold_q - 8'd1;
            end
          end
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // Output decode from next state so flags land one cycle after frame_end
  logic [3:0] flags_d, flags_q;
  logic       en_d, en_q;

  always_comb begin
    flags_d = '0;
    en_d    = 1'b0;
    if (state_d == StActive) begin
      flags_d[act_d] = 1'b1;
      en_d           = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      state_q    <= StIdle;
      cand_q     <= 2'd0;
      conf_q     <= 4'd0;
      act_q      <= 2'd0;
      hold_q     <= 8'd0;
      pend_q     <= 2'd0;
      pend_cnt_q <= 4'd0;
      flags_q    <= '0;
      en_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      conf_q     <= conf_d;
      act_q      <= act_d;
      hold_q     <= hold_d;
      pend_q     <= pend_d;
      pend_cnt_q <= pend_cnt_d;
      flags_q    <= flags_d;
      en_q       <= en_d;
    end
  end

  assign red_flag    = flags_q[0];
  assign green_flag  = flags_q[1];
  assign blue_flag   = flags_q[2];
  assign yellow_flag = flags_q[3];
  assign en_regions  = en_q;

endmodule

// File: tb/tb_region_flag_ctrl.sv
module tb_region_flag_ctrl;

  localparam int TH = 100;
  localparam int CF = 3;
  localparam int HF = 4;
  localparam int HA = 640;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       pix_valid;
  logic [9:0] x_pos;
  logic       hit;
  logic       frame_end;
  logic       red_flag, green_flag, blue_flag, yellow_flag, en_regions;
  logic [4:0] obs;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign obs = {red_flag, green_flag, blue_flag, yellow_flag, en_regions};

  region_flag_ctrl #(
    .H_ACTIVE      (HA),
    .THRESH        (TH),
    .CONFIRM_FRAMES(CF),
    .HOLD_FRAMES   (HF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .pix_valid  (pix_valid),
    .x_pos      (x_pos),
    .hit        (hit),
    .frame_end  (frame_end),
    .red_flag   (red_flag),
    .green_flag (green_flag),
    .blue_flag  (blue_flag),
    .yellow_flag(yellow_flag),
    .en_regions (en_regions)
  );

  // Reference model: the active region (-1 = none), its remaining hold, and
  // the current streak of consecutive wins by one region that is not active.
  int m_act, m_hold, m_run_reg, m_run_len;

  task automatic mdl_reset();
    m_act     = -1;
    m_hold    = 0;
    m_run_reg = -1;
    m_run_len = 0;
  endtask

  task automatic mdl_frame(input int c0, input int c1, input int c2, input int c3);
    int c[4];
    int w;
    c = '{c0, c1, c2, c3};
    w = -1;
    for (int i = 0; i < 4; i++) begin
      if (c[i] >= TH && (w < 0 || c[i] > c[w])) w = i;
    end
    if (w >= 0 && w != m_act) begin
      if (w == m_run_reg && m_run_len > 0) m_run_len++;
      else begin
        m_run_reg = w;
        m_run_len = 1;
      end
    end else begin
      m_run_len = 0;
    end
    if (m_act < 0) begin
      if (m_run_len >= CF) begin
        m_act     = w;
        m_hold    = HF;
        m_run_len = 0;
      end
    end else if (w == m_act) begin
      m_hold = HF;
    end else if (w >= 0 && m_run_len >= CF) begin
      m_act     = w;
      m_hold    = HF;
      m_run_len = 0;
    end else begin
      m_hold--;
      if (m_hold == 0) begin
        m_act     = -1;
        m_run_len = 0;
      end
    end
  endtask

  function automatic logic [4:0] exp_out();
    if (m_act < 0) return 5'b00000;
    return {m_act == 0, m_act == 1, m_act == 2, m_act == 3, 1'b1};
  endfunction

  // Stimulus drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pix_valid = 1'b0;
    hit       = 1'b0;
    frame_end = 1'b0;
    x_pos     = '0;
  endtask

  task automatic drive_at(input int x, input int n);
    for (int k = 0; k < n; k++) begin
      pix_valid = 1'b1;
      hit       = 1'b1;
      x_pos     = 10'(x);
      tick();
    end
    idle_inputs();
  endtask

  // Hits in random order at random x inside each region, with noise cycles
  // (invalid pixel, non-hit pixel, off-screen pixel) that must not count.
  task automatic drive_hits(input int n0, input int n1, input int n2, input int n3);
    int rem[4];
    int r;
    rem = '{n0, n1, n2, n3};
    while (rem[0] + rem[1] + rem[2] + rem[3] > 0) begin
      r = int'($urandom_range(3));
      while (rem[r] == 0) r = (r + 1) % 4;
      pix_valid = 1'b1;
      hit       = 1'b1;
      x_pos     = 10'(r * 160 + int'($urandom_range(159)));
      tick();
      rem[r]--;
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(2))
          0: begin pix_valid = 1'b0; hit = 1'b1; x_pos = 10'($urandom_range(639)); end
          1: begin pix_valid = 1'b1; hit = 1'b0; x_pos = 10'($urandom_range(639)); end
          default: begin pix_valid = 1'b1; hit = 1'b1; x_pos = 10'($urandom_range(1023, 640)); end
        endcase
        tick();
      end
    end
    idle_inputs();
  endtask

  task automatic pulse_end(input bit with_hit);
    frame_end = 1'b1;
    pix_valid = with_hit;
    hit       = with_hit;
    x_pos     = 10'($urandom_range(639));
    tick();
    idle_inputs();
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mdl_reset();
  endtask

  // Scenarios
  task automatic test_reset();
    rst_n  = 1'b0;
    enable = 1'b1;
    idle_inputs();
    repeat (3) tick();
    vectors++;
    if (obs !== 5'b00000) begin
      miscompares++;
      $display("FAIL reset_held: got %b expected %b", obs, 5'b00000);
    end
    rst_n = 1'b1;
    mdl_reset();
    tick();
    vectors++;
    if (obs !== 5'b00000) begin
      miscompares++;
      $display("FAIL reset_release: got %b expected %b", obs, 5'b00000);
    end
  endtask

  task automatic test_confirm();
    for (int f = 1; f <= 3; f++) begin
      drive_at(50, 150);
      pulse_end(1'b0);
      mdl_frame(150, 0, 0, 0);
      vectors++;
      if (obs !== exp_out() || (f < 3 && obs !== 5'b00000) || (f == 3 && obs !== 5'b10001)) begin
        miscompares++;
        $display("FAIL confirm_f%0d: got %b expected %b", f, obs, exp_out());
      end
    end
  endtask

  task automatic test_hold_expire();
    for (int f = 1; f <= 4; f++) begin
      pulse_end(1'b0);
      mdl_frame(0, 0, 0, 0);
      vectors++;
      if (obs !== exp_out() || (f < 4 && obs !== 5'b10001) || (f == 4 && obs !== 5'b00000)) begin
        miscompares++;
        $display("FAIL hold_f%0d: got %b expected %b", f, obs, exp_out());
      end
    end
  endtask

  task automatic test_switch();
    for (int f = 1; f <= 3; f++) begin
      drive_at(50, 150);
      pulse_end(1'b0);
      mdl_frame(150, 0, 0, 0);
    end
    vectors++;
    if (obs !== 5'b10001) begin
      miscompares++;
      $display("FAIL switch_red_on: got %b expected %b", obs, 5'b10001);
    end
    for (int f = 1; f <= 3; f++) begin
      drive_at(500, 200);
      pulse_end(1'b0);
      mdl_frame(0, 0, 0, 200);
      vectors++;
      if (obs !== exp_out() || $countones(obs[4:1]) > 1 || (f == 3 && obs !== 5'b00011)) begin
        miscompares++;
        $display("FAIL switch_f%0d: got %b expected %b", f, obs, exp_out());
      end
    end
  endtask

  task automatic test_tie_and_below();
    do_reset();
    for (int f = 1; f <= 3; f++) begin
      drive_at(200, 120);
      drive_at(400, 120);
      pulse_end(1'b0);
      mdl_frame(0, 120, 120, 0);
    end
    vectors++;
    if (obs !== exp_out() || obs !== 5'b01001) begin
      miscompares++;
      $display("FAIL tie_green: got %b expected %b", obs, 5'b01001);
    end
    do_reset();
    for (int f = 1; f <= 5; f++) begin
      drive_hits(99, 99, 99, 99);
      pulse_end(1'b0);
      mdl_frame(99, 99, 99, 99);
      vectors++;
      if (obs !== 5'b00000) begin
        miscompares++;
        $display("FAIL below_thresh_f%0d: got %b expected %b", f, obs, 5'b00000);
      end
    end
  endtask

  task automatic test_ignored();
    do_reset();
    for (int f = 1; f <= 3; f++) begin
      drive_at(650, 150);
      drive_at(50, 99);
      // The 100th red hit arrives together with frame_end and must be dropped
      frame_end = 1'b1;
      pix_valid = 1'b1;
      hit       = 1'b1;
      x_pos     = 10'd50;
      tick();
      idle_inputs();
      mdl_frame(99, 0, 0, 0);
      vectors++;
      if (obs !== exp_out() || obs !== 5'b00000) begin
        miscompares++;
        $display("FAIL ignored_px_f%0d: got %b expected %b", f, obs, 5'b00000);
      end
    end
  endtask

  task automatic test_midframe_reset();
    do_reset();
    for (int f = 1; f <= 3; f++) begin
      drive_at(50, 150);
      pulse_end(1'b0);
      mdl_frame(150, 0, 0, 0);
    end
    drive_at(50, 90);
    rst_n = 1'b0;
    tick();
    vectors++;
    if (obs !== 5'b00000) begin
      miscompares++;
      $display("FAIL midframe_reset: got %b expected %b", obs, 5'b00000);
    end
    rst_n = 1'b1;
    mdl_reset();
    // 20 post-reset hits must not merge with the 90 pre-reset ones
    drive_at(50, 20);
    pulse_end(1'b0);
    mdl_frame(20, 0, 0, 0);
    for (int f = 1; f <= 2; f++) begin
      drive_at(50, 150);
      pulse_end(1'b0);
      mdl_frame(150, 0, 0, 0);
    end
    vectors++;
    if (obs !== exp_out() || obs !== 5'b00000) begin
      miscompares++;
      $display("FAIL post_reset_count: got %b expected %b", obs, 5'b00000);
    end
  endtask

  task automatic test_enable();
    do_reset();
    for (int f = 1; f <= 3; f++) begin
      drive_at(50, 150);
      pulse_end(1'b0);
      mdl_frame(150, 0, 0, 0);
    end
    enable = 1'b0;
    tick();
    vectors++;
    if (obs !== 5'b00000) begin
      miscompares++;
      $display("FAIL disable_clears: got %b expected %b", obs, 5'b00000);
    end
    drive_at(50, 90);
    pulse_end(1'b0);
    enable = 1'b1;
    mdl_reset();
    drive_at(50, 20);
    pulse_end(1'b0);
    mdl_frame(20, 0, 0, 0);
    for (int f = 1; f <= 2; f++) begin
      drive_at(50, 150);
      pulse_end(1'b0);
      mdl_frame(150, 0, 0, 0);
    end
    vectors++;
    if (obs !== exp_out() || obs !== 5'b00000) begin
      miscompares++;
      $display("FAIL enable_resume: got %b expected %b", obs, 5'b00000);
    end
    drive_at(50, 150);
    pulse_end(1'b0);
    mdl_frame(150, 0, 0, 0);
    vectors++;
    if (obs !== exp_out()) begin
      miscompares++;
      $display("FAIL enable_reactivate: got %b expected %b", obs, exp_out());
    end
  endtask

  task automatic test_random();
    int fav;
    int n[4];
    do_reset();
    fav = 0;
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(4) == 0) fav = int'($urandom_range(3));
      for (int r = 0; r < 4; r++) begin
        n[r] = (r == fav) ? int'($urandom_range(180, 100)) : int'($urandom_range(120));
      end
      if ($urandom_range(5) == 0) n = '{0, 0, 0, 0};
      drive_hits(n[0], n[1], n[2], n[3]);
      vectors++;
      if (obs !== exp_out()) begin
        miscompares++;
        $display("FAIL rand_stable_f%0d: got %b expected %b", f, obs, exp_out());
      end
      pulse_end(1'($urandom_range(1)));
      mdl_frame(n[0], n[1], n[2], n[3]);
      vectors++;
      if (obs !== exp_out()) begin
        miscompares++;
        $display("FAIL rand_eval_f%0d: got %b expected %b (counts %0d %0d %0d %0d)",
                 f, obs, exp_out(), n[0], n[1], n[2], n[3]);
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b1;
    idle_inputs();
    mdl_reset();
    test_reset();
    test_confirm();
    test_hold_expire();
    test_switch();
    test_tie_and_below();
    test_ignored();
    test_midframe_reset();
    test_enable();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
